// File: rtl/m_lap_stop_watch.sv
`default_nettype none
// ============================================================================
// Module   : m_lap_stop_watch
// Purpose  : BCD min:sec:centisecond stopwatch with start/stop, clear, lap
//            capture into a small lap memory and lap recall while paused.
//            The 10 ms tick comes from a programmable prescaler on clk.
// Ports    : clk, n_reset (async, active low)
//            start_sw, lap_sw, clr_sw  - raw push buttons (asynchronous)
//            min, sec, msec            - BCD display value (live or lap)
//            run_led                   - high in RUN
//            lap_view, lap_idx         - lap recall status / displayed entry
//            lap_count, lap_full       - lap memory occupancy
//            overflow                  - sticky wrap past P_MIN_MAX:59.99
// Options  : LAP_STOPWATCH_DEBOUNCE_EN  - when defined, each synchronised
//            button passes through a stable-count debounce filter; when
//            undefined the synchronised level is edge-detected directly.
// Revision : 1.0 - initial release
// ============================================================================
module m_lap_stop_watch #(
    parameter int P_TICK_DIV        = 500000,
    parameter int P_DEBOUNCE_CYCLES = 65536,
    parameter int P_LAP_DEPTH       = 4,
    parameter int P_MIN_MAX         = 99
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       start_sw,
    input  logic       lap_sw,
    input  logic       clr_sw,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic [7:0] msec,
    output logic       run_led,
    output logic       lap_view,
    output logic [3:0] lap_idx,
    output logic [4:0] lap_count,
    output logic       lap_full,
    output logic       overflow
);

    localparam int          c_PW        = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;
    localparam int          c_AW        = (P_LAP_DEPTH > 1) ? $clog2(P_LAP_DEPTH) : 1;
    localparam logic [7:0]  c_MIN_BCD   = {4'(P_MIN_MAX / 10), 4'(P_MIN_MAX % 10)};
    localparam logic [4:0]  c_DEPTH     = 5'(P_LAP_DEPTH);
    localparam logic [c_PW-1:0] c_TERM  = c_PW'(P_TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // ---------------------------------------------------------------- buttons
    // Bit order everywhere: [0]=start, [1]=lap, [2]=clr.
    logic [2:0] w_sw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_level;
    logic [2:0] r_level_d;
    logic [2:0] w_edge;

    assign w_sw = {clr_sw, lap_sw, start_sw};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_sw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef LAP_STOPWATCH_DEBOUNCE_EN
    localparam int c_DW = (P_DEBOUNCE_CYCLES > 1) ? $clog2(P_DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DW-1:0] c_DB_TERM = c_DW'(P_DEBOUNCE_CYCLES - 1);

    for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
        logic [c_DW-1:0] r_cnt;
        logic            r_lvl;

        // The accepted level only moves after the synchronised input has
        // disagreed with it for P_DEBOUNCE_CYCLES consecutive samples.
        always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (r_sync2[gi] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DB_TERM) begin
                r_cnt <= '0;
                r_lvl <= r_sync2[gi];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_level[gi] = r_lvl;
    end
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_level_d <= 3'b000;
        end else begin
            r_level_d <= w_level;
        end
    end

    assign w_edge = w_level & ~r_level_d;

    // Priority clr > start > lap; a losing edge in the same cycle is dropped.
    logic w_clr_ev;
    logic w_start_ev;
    logic w_lap_ev;

    assign w_clr_ev   = w_edge[2];
    assign w_start_ev = w_edge[0] & ~w_edge[2];
    assign w_lap_ev   = w_edge[1] & ~w_edge[0] & ~w_edge[2];

    // -------------------------------------------------------------------- FSM
    state_t r_state;
    state_t w_state_nxt;
    logic   w_do_clr;
    logic   w_do_capture;
    logic   w_do_recall;
    logic   w_exit_view;

    logic [4:0] r_lap_count;
    logic       r_lap_view;
    logic [3:0] r_lap_idx;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_do_clr     = 1'b0;
        w_do_capture = 1'b0;
        w_do_recall  = 1'b0;
        w_exit_view  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ev) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_start_ev) w_state_nxt = S_PAUSE;
                // Full memory drops the capture rather than overwriting.
                w_do_capture = w_lap_ev && (r_lap_count != c_DEPTH);
            end
            S_PAUSE: begin
                if (w_clr_ev) begin
                    w_state_nxt = S_IDLE;
                    w_do_clr    = 1'b1;
                end else if (w_start_ev) begin
                    w_state_nxt = S_RUN;
                    w_exit_view = 1'b1;
                end
                w_do_recall = w_lap_ev && (r_lap_count != 5'd0);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- prescaler
    logic [c_PW-1:0] r_presc;
    logic            w_tick;

    assign w_tick = (r_state == S_RUN) && (r_presc == c_TERM);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_presc <= '0;
        end else if ((r_state == S_IDLE) || w_do_clr || w_tick) begin
            r_presc <= '0;
        end else if (r_state == S_RUN) begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ----------------------------------------------------------- time counter
    logic [3:0] r_cs_u, r_cs_t, r_s_u, r_s_t, r_m_u, r_m_t;
    logic       r_ovf;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset || 1'b0) begin
            {r_m_t, r_m_u, r_s_t, r_s_u, r_cs_t, r_cs_u} <= 24'h0;
            r_ovf <= 1'b0;
        end else if (w_do_clr) begin
            {r_m_t, r_m_u, r_s_t, r_s_u, r_cs_t, r_cs_u} <= 24'h0;
            r_ovf <= 1'b0;
        end else if (w_tick) begin
            if (r_cs_u != 4'd9) r_cs_u <= r_cs_u + 4'd1;
            else begin
                r_cs_u <= 4'd0;
                if (r_cs_t != 4'd9) r_cs_t <= r_cs_t + 4'd1;
                else begin
                    r_cs_t <= 4'd0;
                    if (r_s_u != 4'd9) r_s_u <= r_s_u + 4'd1;
                    else begin
                        r_s_u <= 4'd0;
                        if (r_s_t != 4'd5) r_s_t <= r_s_t + 4'd1;
                        else begin
                            r_s_t <= 4'd0;
                            if ({r_m_t, r_m_u} == c_MIN_BCD) begin
                                // Wrap to zero and keep counting.
                                r_m_t <= 4'd0;
                                r_m_u <= 4'd0;
                                r_ovf <= 1'b1;
                            end else if (r_m_u == 4'd9) begin
                                r_m_u <= 4'd0;
                                r_m_t <= r_m_t + 4'd1;
                            end else begin
                                r_m_u <= r_m_u + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------- lap memory
    // Entries need no reset: r_lap_count defines which ones are valid.
    logic [23:0] r_lap_mem [P_LAP_DEPTH];
    logic [23:0] w_live;
    logic [23:0] w_lap_rd;

    assign w_live   = {r_m_t, r_m_u, r_s_t, r_s_u, r_cs_t, r_cs_u};
    assign w_lap_rd = r_lap_mem[r_lap_idx[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_capture) begin
            r_lap_mem[r_lap_count[c_AW-1:0]] <= w_live;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_lap_count <= 5'd0;
            r_lap_view  <= 1'b0;
            r_lap_idx   <= 4'd0;
        end else if (w_do_clr) begin
            r_lap_count <= 5'd0;
            r_lap_view  <= 1'b0;
            r_lap_idx   <= 4'd0;
        end else begin
            if (w_do_capture) r_lap_count <= r_lap_count + 5'd1;
            if (w_exit_view) begin
                r_lap_view <= 1'b0;
                r_lap_idx  <= 4'd0;
            end else if (w_do_recall) begin
                if (!r_lap_view) begin
                    r_lap_view <= 1'b1;
                    r_lap_idx  <= 4'd0;
                end else if ({1'b0, r_lap_idx} == (r_lap_count - 5'd1)) begin
                    // Stepping past the last valid entry returns to live time.
                    r_lap_view <= 1'b0;
                    r_lap_idx  <= 4'd0;
                end else begin
                    r_lap_idx <= r_lap_idx + 4'd1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign min       = r_lap_view ? w_lap_rd[23:16] : w_live[23:16];
    assign sec       = r_lap_view ? w_lap_rd[15:8]  : w_live[15:8];
    assign msec      = r_lap_view ? w_lap_rd[7:0]   : w_live[7:0];
    assign run_led   = (r_state == S_RUN);
    assign lap_view  = r_lap_view;
    assign lap_idx   = r_lap_idx;
    assign lap_count = r_lap_count;
    assign lap_full  = (r_lap_count == c_DEPTH);
    assign overflow  = r_ovf;

endmodule
`default_nettype wire
